pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
- Drives the dynamic phase-shift inputs of the ECP5 EHXPLLL: PHASESEL, PHASEDIR and PHASESTEP. PLL wrappers currently tie these to 0; this block is the initiator side of that interface.
- Takes a request of {output select, direction, step count} and emits that many correctly timed PHASESTEP pulses.
- Sits in the clock domain that feeds the PLL's phase inputs, next to the PLL wrapper. Reports done, or an abort if lock is lost.

Parameters:
- STEP_W, 8: width of the step-count field (max 2^STEP_W-1 steps per request).
- SETUP_CYC, 4: cycles PHASESEL/PHASEDIR are held stable before the first PHASESTEP; must be >=1.
- PULSE_CYC, 4: cycles PHASESTEP is held active per step; must be >=1.
- GAP_CYC, 8: inactive cycles after each pulse before the next pulse or done; must be >=1.
- STEP_ACTIVE_LOW, 0: 1 = PHASESTEP is active-low (idle high).

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- locked  in  1  PLL LOCK. Treated as synchronous to clk; a synchroniser is the integrator's job.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_sel  in  2  PLL output to shift (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3).
- req_dir  in  1  0 = lag/increase delay, 1 = lead; passed straight to PHASEDIR.
- req_steps  in  STEP_W  number of phase steps.
- phasesel  out  2  to PLL PHASESEL1:0.
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse on normal completion.
- abort  out  1  one-cycle pulse when lock is lost mid-request.

Behaviour:
- Reset values (async on rst_n low): state IDLE, phasesel=0, phasedir=0, phasestep=STEP_ACTIVE_LOW (inactive), busy=0, done=0, abort=0, counters 0.
- All outputs except req_ready are registered. req_ready = (state==IDLE) && locked, combinational.
- Request accepted at clock edge k:
  - req_sel, req_dir and req_steps are captured.
  - phasesel/phasedir take the new values from edge k; they hold until the next accept and do not revert to 0 in IDLE.
  - busy rises at edge k.
- States:
  - IDLE: wait for accept. If req_steps==0, go to FINISH; otherwise go to SETUP.
  - SETUP: SETUP_CYC cycles, phasestep inactive, then go to PULSE.
  - PULSE: phasestep active for PULSE_CYC cycles, then go to GAP.
  - GAP: phasestep inactive for GAP_CYC cycles. The remaining-step count decrements on entry to GAP. If the count is now 0, go to FINISH; else go to PULSE.
  - FINISH: one cycle. done=1, busy drops on the following edge, then return to IDLE.
- Timing: phasestep is active from edge k+SETUP_CYC+j*(PULSE_CYC+GAP_CYC) for exactly PULSE_CYC cycles, j=0..N-1. done is high in the cycle after edge k+SETUP_CYC+N*(PULSE_CYC+GAP_CYC). The zero-step case gives done after edge k+1 with no pulses.
- Lock loss: locked==0 sampled in SETUP, PULSE or GAP causes, at the next edge:
  - phasestep inactive, abort=1 for one cycle, done not asserted;
  - state returns to IDLE and busy=0.
  - Steps already issued are not undone.
- Lock loss in FINISH is ignored; done still fires.
- No new request is accepted while busy. req_valid may stay high; it is accepted the cycle after return to IDLE if locked.
- Counters are sized from the parameters: phase-cycle counter is clog2(max(SETUP_CYC,PULSE_CYC,GAP_CYC)+1) bits; step counter is STEP_W bits. Neither wraps: steps are bounded by req_steps, which is at most 2^STEP_W-1.
- Reset asserted mid-request: phasestep goes inactive immediately (asynchronously); the request is dropped with no done or abort.

Decomposition:
- Shared package pll_pkg holds:
  - enum of state codes;
  - PLL output select localparams CLKOP/CLKOS/CLKOS2/CLKOS3 = 0..3;
  - the PHASEDIR encoding.
- Single module; no sub-module. The timing counter is inline.

Test Plan:
- Defaults, locked=1, request sel=1 dir=1 steps=3 at edge k -> phasesel=1 and phasedir=1 from k; phasestep high in cycles k+4..k+7, k+16..k+19, k+28..k+31; done single pulse after edge k+40; busy falls at k+41.
- steps=0 -> done after edge k+1, phasestep never asserted, busy high for 2 cycles.
- locked=0 with req_valid=1 -> req_ready=0, no accept. Raising locked -> accept that cycle.
- locked dropped during the 2nd pulse of a steps=5 request -> phasestep inactive next edge, abort pulse, no done, exactly 2 pulses seen, req_ready returns once locked=1.
- Back-to-back: req_valid held high with two queued requests -> second accepted the first cycle after FINISH; no overlap of busy periods; phasesel switches only at the second accept.
- STEP_ACTIVE_LOW=1, rst_n pulsed low during PULSE -> phasestep reads 1 immediately, all other outputs at reset values; the next request runs normally.

Source files
------------

// File: rtl/pll_phase_ctrl_pkg.sv
// Shared definitions for the ECP5 EHXPLLL dynamic phase-shift controller.
//   state_e            : controller state codes (also exported on the debug port)
//   CLKOP..CLKOS3      : PHASESEL encodings of the PLL outputs
//   DIR_LAG / DIR_LEAD : PHASEDIR encodings
//   max3()             : helper used to size the phase-cycle counter
package pll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam logic [1:0] CLKOP  = 2'd0;
   localparam logic [1:0] CLKOS  = 2'd1;
   localparam logic [1:0] CLKOS2 = 2'd2;
   localparam logic [1:0] CLKOS3 = 2'd3;

   localparam logic DIR_LAG  = 1'b0;  // increase delay
   localparam logic DIR_LEAD = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Request channel of the phase-shift controller.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
// The initiator may hold req_valid high across busy periods; req_sel/req_dir/
// req_steps must be stable while req_valid is high and not yet accepted.
//   master : drives req_valid, req_sel, req_dir, req_steps; samples req_ready
//   slave  : the controller side
interface pll_phase_ctrl_if #(
   parameter int STEP_W = 8
) ();
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_sel;
   logic              req_dir;
   logic [STEP_W-1:0] req_steps;

   modport master (output req_valid, req_sel, req_dir, req_steps, input req_ready);
   modport slave  (input req_valid, req_sel, req_dir, req_steps, output req_ready);
endinterface

// File: rtl/pll_phase_ctrl.sv
// Initiator for the EHXPLLL dynamic phase-shift port. Accepts {sel, dir, steps}
// requests and emits that many PHASESTEP pulses with setup/pulse/gap timing.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   locked       : PLL LOCK, already synchronous to clk
//   req          : request channel (slave modport)
//   phasesel/phasedir/phasestep : to the PLL
//   busy, done, abort           : status (done/abort are one-cycle pulses)
//   dbg_state    : current FSM state
module pll_phase_ctrl
   import pll_pkg::*;
#(
   parameter int STEP_W          = 8,
   parameter int SETUP_CYC       = 4,
   parameter int PULSE_CYC       = 4,
   parameter int GAP_CYC         = 8,
   parameter int STEP_ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             locked,
   pll_phase_ctrl_if.slave  req,
   output logic [1:0]       phasesel,
   output logic             phasedir,
   output logic             phasestep,
   output logic             busy,
   output logic             done,
   output logic             abort,
   output state_e           dbg_state
);

   localparam int   CNT_W     = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
   localparam logic STEP_IDLE = (STEP_ACTIVE_LOW != 0);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [1:0]        sel_d;
   logic              dir_d, step_d, busy_d, done_d, abort_d;

   assign req.req_ready = (state_q == ST_IDLE) && locked;
   assign dbg_state     = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         steps_q   <= '0;
         phasesel  <= '0;
         phasedir  <= 1'b0;
         phasestep <= STEP_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         abort     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         steps_q   <= steps_d;
         phasesel  <= sel_d;
         phasedir  <= dir_d;
         phasestep <= step_d;
         busy      <= busy_d;
         done      <= done_d;
         abort     <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      steps_d = steps_q;
      sel_d   = phasesel;
      dir_d   = phasedir;
      abort_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req.req_valid && locked) begin
               sel_d   = req.req_sel;
               dir_d   = req.req_dir;
               steps_d = req.req_steps;
               if (req.req_steps == '0) begin
                  // cnt=1 makes FINISH last one extra cycle so done lands after k+1
                  state_d = ST_FINISH;
                  cnt_d   = CNT_W'(1);
               end else begin
                  state_d = ST_SETUP;
                  cnt_d   = '0;
               end
            end
         end
         ST_SETUP: begin
            if (!locked) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               abort_d = 1'b1;
            end else if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
               state_d = ST_PULSE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PULSE: begin
            if (!locked) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               abort_d = 1'b1;
            end else if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               steps_d = steps_q - STEP_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (!locked) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               abort_d = 1'b1;
            end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
               state_d = (steps_q == '0) ? ST_FINISH : ST_PULSE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FINISH: begin
            // lock is deliberately ignored here
            if (cnt_q != '0) begin
               cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      done_d = (state_d == ST_FINISH) && (cnt_d == '0);
      busy_d = (state_d != ST_IDLE);
      step_d = (state_d == ST_PULSE) ? ~STEP_IDLE : STEP_IDLE;
   end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: a default instance (dut0) and an
// active-low PHASESTEP instance (dut1). A monitor logs timestamped events; each
// test pushes the events it expects and compares them in order.
module tb_pll_phase_ctrl;
   import pll_pkg::*;

   localparam int EV_SEL = 1, EV_BRISE = 2, EV_STEP = 3, EV_DONE = 4,
                  EV_ABORT = 5, EV_BFALL = 6, EV_STEP1 = 7, EV_DONE1 = 8;

   logic clk = 1'b0;
   logic rst0_n = 1'b0, rst1_n = 1'b0;
   logic locked = 1'b1;
   int   cyc = 0;

   logic [1:0] phasesel0, phasesel1;
   logic       phasedir0, phasedir1, phasestep0, phasestep1;
   logic       busy0, busy1, done0, done1, abort0, abort1;
   state_e     st0, st1;

   pll_phase_ctrl_if #(.STEP_W(8)) bus0 ();
   pll_phase_ctrl_if #(.STEP_W(8)) bus1 ();

   pll_phase_ctrl #(.STEP_ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .locked(locked), .req(bus0.slave),
      .phasesel(phasesel0), .phasedir(phasedir0), .phasestep(phasestep0),
      .busy(busy0), .done(done0), .abort(abort0), .dbg_state(st0));

   pll_phase_ctrl #(.STEP_ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .locked(locked), .req(bus1.slave),
      .phasesel(phasesel1), .phasedir(phasedir1), .phasestep(phasestep1),
      .busy(busy1), .done(done1), .abort(abort1), .dbg_state(st1));

   // clock / cycle stamp: at the negedge after edge e, cyc == e
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int hi_cnt   = 0;

   function automatic logic [31:0] ev(input int t, input int c);
      return {t[3:0], c[27:0]};
   endfunction

   // monitor
   logic [1:0] p_sel = 2'd0;
   logic p_step = 1'b0, p_busy = 1'b0, p_step1 = 1'b1;
   always @(negedge clk) begin
      if (phasesel0 != p_sel)       obs_q.push_back(ev(EV_SEL, cyc));
      if (busy0 && !p_busy)         obs_q.push_back(ev(EV_BRISE, cyc));
      if (phasestep0 && !p_step)    obs_q.push_back(ev(EV_STEP, cyc));
      if (done0)                    obs_q.push_back(ev(EV_DONE, cyc));
      if (abort0)                   obs_q.push_back(ev(EV_ABORT, cyc));
      if (!busy0 && p_busy)         obs_q.push_back(ev(EV_BFALL, cyc));
      if (!phasestep1 && p_step1)   obs_q.push_back(ev(EV_STEP1, cyc));
      if (done1)                    obs_q.push_back(ev(EV_DONE1, cyc));
      if (phasestep0) hi_cnt++;
      p_sel   = phasesel0;
      p_busy  = busy0;
      p_step  = phasestep0;
      p_step1 = phasestep1;
   end

   // driver: present a request, wait for acceptance, return accept edge k
   task automatic drive_req(input bit which, input logic [1:0] sel, input logic dir,
                            input logic [7:0] steps, input bit hold, output int k);
      int  waited;
      logic rdy;
      @(negedge clk);
      if (!which) begin
         bus0.req_sel = sel; bus0.req_dir = dir; bus0.req_steps = steps; bus0.req_valid = 1'b1;
      end else begin
         bus1.req_sel = sel; bus1.req_dir = dir; bus1.req_steps = steps; bus1.req_valid = 1'b1;
      end
      waited = 0;
      rdy = which ? bus1.req_ready : bus0.req_ready;
      while (!rdy && waited < 200) begin
         @(negedge clk);
         waited++;
         rdy = which ? bus1.req_ready : bus0.req_ready;
      end
      if (!rdy) begin
         n_checks++; n_fail++;
         $display("FAIL drive_req_timeout: req_ready stayed 0 for %0d cycles, required 1", waited);
      end
      k = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
         if (!which) bus0.req_valid = 1'b0; else bus1.req_valid = 1'b0;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++; if (phasesel0 !== 2'd0) begin n_fail++; $display("FAIL rst_phasesel: got %0d required 0", phasesel0); end
      n_checks++; if (phasedir0 !== 1'b0) begin n_fail++; $display("FAIL rst_phasedir: got %b required 0", phasedir0); end
      n_checks++; if (phasestep0 !== 1'b0) begin n_fail++; $display("FAIL rst_phasestep: got %b required 0", phasestep0); end
      n_checks++; if (phasestep1 !== 1'b1) begin n_fail++; $display("FAIL rst_phasestep_al: got %b required 1", phasestep1); end
      n_checks++; if ({busy0, done0, abort0} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b required 000", {busy0, done0, abort0}); end
      n_checks++; if (st0 !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", st0, ST_IDLE); end
      n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", bus0.req_ready); end
   endtask

   task automatic test_basic();
      int k;
      logic [31:0] e, o;
      obs_q.delete(); hi_cnt = 0;
      drive_req(0, CLKOS, DIR_LEAD, 8'd3, 0, k);
      exp_q.push_back(ev(EV_SEL, k));  exp_q.push_back(ev(EV_BRISE, k));
      exp_q.push_back(ev(EV_STEP, k + 4)); exp_q.push_back(ev(EV_STEP, k + 16));
      exp_q.push_back(ev(EV_STEP, k + 28)); exp_q.push_back(ev(EV_DONE, k + 40));
      exp_q.push_back(ev(EV_BFALL, k + 41));
      wait_until(k + 46);
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_event: got type %0d cyc %0d required type %0d cyc %0d", o[31:28], o[27:0], e[31:28], e[27:0]); end
      end
      n_checks++; if (hi_cnt != 12) begin n_fail++; $display("FAIL basic_step_cycles: got %0d required 12", hi_cnt); end
      n_checks++; if ({phasesel0, phasedir0} !== {CLKOS, DIR_LEAD}) begin n_fail++; $display("FAIL basic_sel_dir_hold: got %b required %b", {phasesel0, phasedir0}, {CLKOS, DIR_LEAD}); end
   endtask

   task automatic test_zero_steps();
      int k;
      logic [31:0] e, o;
      obs_q.delete(); hi_cnt = 0;
      drive_req(0, CLKOS2, DIR_LAG, 8'd0, 0, k);
      exp_q.push_back(ev(EV_SEL, k)); exp_q.push_back(ev(EV_BRISE, k));
      exp_q.push_back(ev(EV_DONE, k + 1)); exp_q.push_back(ev(EV_BFALL, k + 2));
      wait_until(k + 8);
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL zero_event: got type %0d cyc %0d required type %0d cyc %0d", o[31:28], o[27:0], e[31:28], e[27:0]); end
      end
      n_checks++; if (hi_cnt != 0) begin n_fail++; $display("FAIL zero_step_cycles: got %0d required 0", hi_cnt); end
   endtask

   task automatic test_lock_gate();
      int k;
      logic [31:0] e, o;
      obs_q.delete();
      @(negedge clk);
      locked = 1'b0;
      bus0.req_sel = CLKOS3; bus0.req_dir = DIR_LAG; bus0.req_steps = 8'd1; bus0.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (bus0.req_ready !== 1'b0) begin n_fail++; $display("FAIL gate_ready_unlocked: got %b required 0", bus0.req_ready); end
         n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL gate_busy_unlocked: got %b required 0", busy0); end
         @(negedge clk);
      end
      locked = 1'b1;
      #1;
      n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL gate_ready_locked: got %b required 1", bus0.req_ready); end
      k = cyc + 1;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      exp_q.push_back(ev(EV_SEL, k)); exp_q.push_back(ev(EV_BRISE, k));
      exp_q.push_back(ev(EV_STEP, k + 4)); exp_q.push_back(ev(EV_DONE, k + 16));
      exp_q.push_back(ev(EV_BFALL, k + 17));
      wait_until(k + 20);
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gate_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL gate_event: got type %0d cyc %0d required type %0d cyc %0d", o[31:28], o[27:0], e[31:28], e[27:0]); end
      end
   endtask

   task automatic test_lock_loss();
      int k;
      logic [31:0] e, o;
      obs_q.delete(); hi_cnt = 0;
      drive_req(0, CLKOP, DIR_LEAD, 8'd5, 0, k);
      exp_q.push_back(ev(EV_SEL, k)); exp_q.push_back(ev(EV_BRISE, k));
      exp_q.push_back(ev(EV_STEP, k + 4)); exp_q.push_back(ev(EV_STEP, k + 16));
      exp_q.push_back(ev(EV_ABORT, k + 18)); exp_q.push_back(ev(EV_BFALL, k + 18));
      while (cyc < k + 17) @(negedge clk);
      locked = 1'b0;                      // sampled low at edge k+18, mid 2nd pulse
      while (cyc < k + 19) @(negedge clk);
      #1;
      n_checks++; if (phasestep0 !== 1'b0) begin n_fail++; $display("FAIL loss_step_inactive: got %b required 0", phasestep0); end
      n_checks++; if (bus0.req_ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready_unlocked: got %b required 0", bus0.req_ready); end
      @(negedge clk);
      locked = 1'b1;
      #1;
      n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL loss_ready_relock: got %b required 1", bus0.req_ready); end
      wait_until(k + 40);
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL loss_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL loss_event: got type %0d cyc %0d required type %0d cyc %0d", o[31:28], o[27:0], e[31:28], e[27:0]); end
      end
      n_checks++; if (hi_cnt != 6) begin n_fail++; $display("FAIL loss_step_cycles: got %0d required 6", hi_cnt); end
   endtask

   task automatic test_back_to_back();
      int ka, kb;
      logic [31:0] e, o;
      obs_q.delete();
      drive_req(0, CLKOS, DIR_LAG, 8'd2, 1, ka);
      drive_req(0, CLKOS2, DIR_LEAD, 8'd1, 0, kb);
      exp_q.push_back(ev(EV_SEL, ka)); exp_q.push_back(ev(EV_BRISE, ka));
      exp_q.push_back(ev(EV_STEP, ka + 4)); exp_q.push_back(ev(EV_STEP, ka + 16));
      exp_q.push_back(ev(EV_DONE, ka + 28)); exp_q.push_back(ev(EV_BFALL, ka + 29));
      exp_q.push_back(ev(EV_SEL, ka + 30)); exp_q.push_back(ev(EV_BRISE, ka + 30));
      exp_q.push_back(ev(EV_STEP, ka + 34)); exp_q.push_back(ev(EV_DONE, ka + 46));
      exp_q.push_back(ev(EV_BFALL, ka + 47));
      wait_until(ka + 52);
      n_checks++; if (kb != ka + 30) begin n_fail++; $display("FAIL b2b_second_accept: got edge %0d required %0d", kb, ka + 30); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_event: got type %0d cyc %0d required type %0d cyc %0d", o[31:28], o[27:0], e[31:28], e[27:0]); end
      end
      n_checks++; if (phasedir0 !== DIR_LEAD) begin n_fail++; $display("FAIL b2b_dir: got %b required 1", phasedir0); end
   endtask

   task automatic test_reset_mid_pulse();
      int k, k2;
      logic [31:0] e, o;
      obs_q.delete();
      drive_req(1, CLKOS3, DIR_LEAD, 8'd2, 0, k);
      exp_q.push_back(ev(EV_STEP1, k + 4));
      while (cyc < k + 5) @(negedge clk);
      n_checks++; if (phasestep1 !== 1'b0) begin n_fail++; $display("FAIL al_step_active: got %b required 0", phasestep1); end
      #2 rst1_n = 1'b0;
      #1;
      n_checks++; if (phasestep1 !== 1'b1) begin n_fail++; $display("FAIL al_rst_step: got %b required 1", phasestep1); end
      n_checks++; if ({phasesel1, phasedir1, busy1, done1, abort1} !== 6'b0) begin n_fail++; $display("FAIL al_rst_outputs: got %b required 000000", {phasesel1, phasedir1, busy1, done1, abort1}); end
      n_checks++; if (st1 !== ST_IDLE) begin n_fail++; $display("FAIL al_rst_state: got %0d required %0d", st1, ST_IDLE); end
      @(negedge clk);
      rst1_n = 1'b1;
      drive_req(1, CLKOS, DIR_LAG, 8'd1, 0, k2);
      exp_q.push_back(ev(EV_STEP1, k2 + 4)); exp_q.push_back(ev(EV_DONE1, k2 + 16));
      wait_until(k2 + 20);
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL al_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL al_event: got type %0d cyc %0d required type %0d cyc %0d", o[31:28], o[27:0], e[31:28], e[27:0]); end
      end
      n_checks++; if (phasesel1 !== CLKOS) begin n_fail++; $display("FAIL al_sel_after: got %0d required 1", phasesel1); end
   endtask

   initial begin
      bus0.req_valid = 1'b0; bus0.req_sel = 2'd0; bus0.req_dir = 1'b0; bus0.req_steps = 8'd0;
      bus1.req_valid = 1'b0; bus1.req_sel = 2'd0; bus1.req_dir = 1'b0; bus1.req_steps = 8'd0;
      repeat (3) @(negedge clk);
      #1;
      test_reset();
      rst0_n = 1'b1; rst1_n = 1'b1;
      repeat (2) @(negedge clk);
      test_basic();
      test_zero_steps();
      test_lock_gate();
      test_lock_loss();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
